// File: rtl/audio_pkg.sv
// Shared audio constants and types for the DAC-side I2S path.
package audio_pkg;

    localparam int SLOT_BITS   = 32;
    localparam int FRAME_SLOTS = 64;
    localparam int SLOT_CNT_W  = $clog2(FRAME_SLOTS);

    typedef logic [SLOT_BITS-1:0] audio_word_t;
    typedef logic signed [15:0]   sample_t;

    // Which half of the I2S frame a slot belongs to (matches the lrclk level).
    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } channel_t;

    // Slots 0..31 are the left half of the frame, slots 32..63 the right half.
    function automatic channel_t slot_channel(input logic [SLOT_CNT_W-1:0] slot);
        return slot[SLOT_CNT_W-1] ? CH_RIGHT : CH_LEFT;
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock generator: divides the system clock down to bclk and provides
// one-clock strobes that mark the clock in which bclk rises or falls.
module i2s_bclk_gen #(
    parameter int unsigned BCLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic bclk,
    output logic fall_evt,
    output logic rise_evt
);

    localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

    logic [7:0] div_cnt;
    logic       wrap;

    assign wrap     = (div_cnt == DIV_LAST);
    assign fall_evt = wrap & bclk;
    assign rise_evt = wrap & ~bclk;

    // Half-period counter; bclk flips every BCLK_DIV clocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// I2S master transmitter: sends the same 32-bit word in the left and right
// slots of every 64-slot frame, using the standard one-bit data delay.
module i2s_tx
    import audio_pkg::*;
#(
    parameter int unsigned BCLK_DIV = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [SLOT_BITS-1:0] tx_data,
    output logic                 bclk,
    output logic                 lrclk,
    output logic                 sdout,
    output logic                 sample_tick
);

    logic                    fall_evt;
    logic                    rise_evt;
    logic                    unused_rise;
    logic [SLOT_CNT_W-1:0]   bit_cnt;
    logic [SLOT_CNT_W-1:0]   next_slot;
    logic [2*SLOT_BITS-1:0]  shreg;
    logic                    load;

    i2s_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk      (clk),
        .reset    (reset),
        .bclk     (bclk),
        .fall_evt (fall_evt),
        .rise_evt (rise_evt)
    );

    // Data only ever moves on falling bclk, so the rising strobe is not needed here.
    assign unused_rise = rise_evt;

    assign next_slot = bit_cnt + 1'b1;
    assign load      = fall_evt && (bit_cnt == '0);
    assign sdout     = shreg[2*SLOT_BITS-1];

    // Slot counter, word select and shifter all advance on the falling bclk event;
    // the word is captured when entering slot 1 so its MSB follows lrclk by one bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt     <= '0;
            shreg       <= '0;
            lrclk       <= 1'b0;
            sample_tick <= 1'b0;
        end else begin
            sample_tick <= load;
            if (fall_evt) begin
                bit_cnt <= next_slot;
                lrclk   <= (slot_channel(next_slot) == CH_RIGHT);
                if (load) begin
                    shreg <= {tx_data, tx_data};
                end else begin
                    shreg <= {shreg[2*SLOT_BITS-2:0], 1'b0};
                end
            end
        end
    end

endmodule
